// File: rtl/instr_issue_queue.sv
// Instruction FIFO feeding the controller decoder: issues at most one instruction
// per cycle, drops unsupported opcodes, and holds off issue while the array streams.
module instr_issue_queue #(
  parameter int DEPTH      = 16,
  parameter int INSTR_W    = 64,
  parameter int STREAM_LEN = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [INSTR_W-1:0]       host_instr,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic                     flush,
  input  logic                     array_busy,
  output logic [INSTR_W-1:0]       instruction,
  output logic                     issue_valid,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     bad_opcode
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(STREAM_LEN) + 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(STREAM_LEN - 1);

  typedef enum logic {RUN, HOLD} state_t;

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [HW-1:0]      hold_q;
  state_t             state_q;
  logic [INSTR_W-1:0] instr_q;
  logic               issue_valid_q, bad_q;

  logic [INSTR_W-1:0] head;
  logic [4:0]         opc;
  logic               push, pop, opc_ok, opc_stream;

  assign head       = mem_q[rd_ptr_q];
  assign opc        = head[4:0];
  // Readiness looks only at the registered count, so a full queue never accepts
  // even on a cycle that pops.
  assign host_ready = rst_n && (count_q < CW'(DEPTH));

  always_comb begin
    push       = host_valid && host_ready && !flush;
    pop        = (state_q == RUN) && (count_q != '0) && !array_busy && !flush;
    opc_ok     = (opc <= 5'd7) || (opc == 5'h1f);
    opc_stream = (opc == 5'd1) || (opc == 5'd2);
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d    = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= host_instr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= RUN;
      hold_q        <= '0;
      instr_q       <= '0;
      issue_valid_q <= 1'b0;
      bad_q         <= 1'b0;
    end else if (flush) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= RUN;
      hold_q        <= '0;
      instr_q       <= '0;
      issue_valid_q <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      instr_q       <= (pop && opc_ok) ? head : '0;
      issue_valid_q <= pop && opc_ok;
      if (pop && !opc_ok) bad_q <= 1'b1;
      case (state_q)
        RUN: begin
          if (pop && opc_ok && opc_stream) begin
            state_q <= HOLD;
            hold_q  <= HOLD_INIT;
          end
        end
        HOLD: begin
          if (hold_q == '0) state_q <= RUN;
          else              hold_q  <= hold_q - HW'(1);
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign instruction = instr_q;
  assign issue_valid = issue_valid_q;
  assign q_count     = count_q;
  assign bad_opcode  = bad_q;

endmodule
